// File: rtl/song_pkg.sv
// Shared definitions for the song reader: ROM word layout, meta codes and FSM states.
package song_pkg;

    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;
    localparam int META_MSB = 2;
    localparam int META_LSB = 0;

    localparam logic [2:0] META_NOTE  = 3'b000;
    localparam logic [2:0] META_CHORD = 3'b001;
    localparam logic [2:0] META_REST  = 3'b010;
    localparam logic [2:0] META_END   = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        DECODE,
        LOAD,
        WAIT_BEATS,
        DONE
    } state_t;

endpackage

// File: rtl/song_reader.sv
// Walks a song ROM entry by entry, emitting note loads to the note players and
// pacing them by beat pulses; stops at an end marker or the last address.
module song_reader
    import song_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              beat,
    input  logic              new_song,
    input  logic [1:0]        song_select,
    output logic [ADDR_W+1:0] rom_addr,
    input  logic [14:0]       rom_data,
    output logic [14:0]       song_note,
    output logic              load_new_note,
    output logic              song_done
);

    state_t            state_reg, state_next, after_entry;
    logic [ADDR_W-1:0] note_addr_reg;
    logic [5:0]        beat_cnt_reg;
    logic [1:0]        song_sel_reg;
    logic [2:0]        meta_reg;
    logic [5:0]        dur_reg;
    logic [14:0]       song_note_reg;
    logic              last_reg;
    logic [2:0]        rom_meta;
    logic              beats_met;

    assign rom_meta = rom_data[META_MSB:META_LSB];

    always_comb begin
        // An entry decoded at the top address is the final one: finish instead of wrapping.
        after_entry = last_reg ? DONE : FETCH;
        beats_met   = (beat_cnt_reg == dur_reg) ||
                      (beat && (beat_cnt_reg + 6'd1 == dur_reg));
        state_next  = state_reg;
        case (state_reg)
            IDLE:       if (play) state_next = FETCH;
            FETCH:      state_next = WAIT_ROM;
            WAIT_ROM:   state_next = DECODE;
            DECODE: begin
                if (rom_meta == META_END)       state_next = DONE;
                else if (rom_meta == META_REST) state_next = WAIT_BEATS;
                else                            state_next = LOAD;
            end
            LOAD: begin
                if (meta_reg == META_CHORD || dur_reg == 6'd0) state_next = after_entry;
                else                                           state_next = WAIT_BEATS;
            end
            WAIT_BEATS: if (play && beats_met) state_next = after_entry;
            DONE:       state_next = DONE;
            default:    state_next = IDLE;
        endcase
        if (new_song) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            note_addr_reg <= '0;
            beat_cnt_reg  <= '0;
            song_sel_reg  <= '0;
            meta_reg      <= '0;
            dur_reg       <= '0;
            song_note_reg <= '0;
            last_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (new_song) begin
                note_addr_reg <= '0;
                beat_cnt_reg  <= '0;
                song_sel_reg  <= song_select;
                last_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    DECODE: begin
                        meta_reg     <= rom_meta;
                        dur_reg      <= rom_data[DUR_MSB:DUR_LSB];
                        beat_cnt_reg <= '0;
                        if (rom_meta != META_END) begin
                            note_addr_reg <= note_addr_reg + ADDR_W'(1);
                            if (&note_addr_reg) last_reg <= 1'b1;
                        end
                        // song_note only changes for entries that actually load
                        if (state_next == LOAD) song_note_reg <= rom_data;
                    end
                    WAIT_BEATS: if (play && beat) beat_cnt_reg <= beat_cnt_reg + 6'd1;
                    default: ;
                endcase
            end
        end
    end

    assign rom_addr      = {song_sel_reg, note_addr_reg};
    assign song_note     = song_note_reg;
    assign load_new_note = (state_reg == LOAD) && !new_song;
    assign song_done     = (state_reg == DONE);

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: directed timing scenarios plus randomized
// songs checked against a load-sequence scoreboard.
module tb_song_reader;
    import song_pkg::*;

    logic        clk = 1'b0;
    logic        reset, play, beat, new_song;
    logic [1:0]  song_select;
    logic [8:0]  rom_addr;
    logic [14:0] rom_data, song_note;
    logic        load_new_note, song_done;
    logic [3:0]  rom_addr2;
    logic [14:0] rom_data2, song_note2;
    logic        load2, done2;

    logic [14:0] rom7 [0:511];
    logic [14:0] rom2 [0:15];

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom7[rom_addr];
        rom_data2 <= rom2[rom_addr2];
    end

    song_reader #(.ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .new_song(new_song),
        .song_select(song_select), .rom_addr(rom_addr), .rom_data(rom_data),
        .song_note(song_note), .load_new_note(load_new_note), .song_done(song_done)
    );

    song_reader #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .play(play), .beat(beat), .new_song(new_song),
        .song_select(song_select), .rom_addr(rom_addr2), .rom_data(rom_data2),
        .song_note(song_note2), .load_new_note(load2), .song_done(done2)
    );

    function automatic logic [14:0] w(int n, int d, logic [2:0] m);
        return {n[5:0], d[5:0], m};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_fresh;
        reset = 1'b0; play = 1'b0; beat = 1'b0; new_song = 1'b0; song_select = 2'd0;
        for (int i = 0; i < 512; i++) rom7[i] = w(0, 0, META_END);
        for (int i = 0; i < 16; i++) rom2[i] = w(0, 0, META_END);
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b0; play = 1'b0; beat = 1'b0; new_song = 1'b0; song_select = 2'd0;
        tick();
        total_cnt++; if (rom_addr !== 9'd0) $display("FAIL reset_rom_addr got %0h exp 0", rom_addr); else pass_cnt++;
        total_cnt++; if (song_note !== 15'd0) $display("FAIL reset_song_note got %0h exp 0", song_note); else pass_cnt++;
        total_cnt++; if (load_new_note !== 1'b0) $display("FAIL reset_load got %0b exp 0", load_new_note); else pass_cnt++;
        total_cnt++; if (song_done !== 1'b0) $display("FAIL reset_done got %0b exp 0", song_done); else pass_cnt++;
        total_cnt++; if (done2 !== 1'b0 || load2 !== 1'b0) $display("FAIL reset_dut2 got done=%0b load=%0b exp 0/0", done2, load2); else pass_cnt++;
        $display("reset: outputs checked");
    endtask

    task automatic test_single_note;
        logic [14:0] w0;
        start_fresh();
        w0 = w(12, 2, META_NOTE);
        rom7[0] = w0;
        play = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            beat = (c % 10 == 9);
            total_cnt++; if (load_new_note !== (c == 4)) $display("FAIL single_load c=%0d got %0b exp %0b", c, load_new_note, c == 4); else pass_cnt++;
            if (c == 4) begin
                total_cnt++; if (song_note !== w0) $display("FAIL single_note got %0h exp %0h", song_note, w0); else pass_cnt++;
            end
            if (c == 20) begin
                total_cnt++; if (dut.state_reg !== FETCH || rom_addr !== 9'd1) $display("FAIL single_fetch1 got state=%0d addr=%0h exp FETCH/1", dut.state_reg, rom_addr); else pass_cnt++;
            end
            total_cnt++; if (song_done !== (c >= 23)) $display("FAIL single_done c=%0d got %0b exp %0b", c, song_done, c >= 23); else pass_cnt++;
            tick();
        end
        $display("single_note: load at 4, fetch of entry 1 at 20, done at 23");
    endtask

    task automatic test_chord;
        logic [14:0] words [0:2];
        start_fresh();
        words[0] = w(10, 5, META_CHORD);
        words[1] = w(20, 0, META_CHORD);
        words[2] = w(30, 1, META_NOTE);
        for (int i = 0; i < 3; i++) rom7[i] = words[i];
        play = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            logic exp_load;
            // beat at 12 coincides with the last LOAD and must not count
            beat = (c == 12 || c == 20);
            exp_load = (c == 4 || c == 8 || c == 12);
            total_cnt++; if (load_new_note !== exp_load) $display("FAIL chord_load c=%0d got %0b exp %0b", c, load_new_note, exp_load); else pass_cnt++;
            if (exp_load) begin
                total_cnt++; if (song_note !== words[(c - 4) / 4]) $display("FAIL chord_note c=%0d got %0h exp %0h", c, song_note, words[(c - 4) / 4]); else pass_cnt++;
            end
            if (c == 16) begin
                total_cnt++; if (song_note !== words[2]) $display("FAIL chord_hold got %0h exp %0h", song_note, words[2]); else pass_cnt++;
            end
            if (c == 21) begin
                total_cnt++; if (dut.state_reg !== FETCH) $display("FAIL chord_fetch got %0d exp FETCH", dut.state_reg); else pass_cnt++;
            end
            total_cnt++; if (song_done !== (c >= 24)) $display("FAIL chord_done c=%0d got %0b exp %0b", c, song_done, c >= 24); else pass_cnt++;
            tick();
        end
        $display("chord: loads at 4/8/12, fetch at 21, done at 24");
    endtask

    task automatic test_rest_end;
        start_fresh();
        rom7[0] = w(0, 3, META_REST);
        play = 1'b1;
        for (int c = 0; c <= 40; c++) begin
            beat = (c == 10 || c == 20 || c == 30);
            total_cnt++; if (load_new_note !== 1'b0) $display("FAIL rest_load c=%0d got %0b exp 0", c, load_new_note); else pass_cnt++;
            total_cnt++; if (song_done !== (c >= 34)) $display("FAIL rest_done c=%0d got %0b exp %0b", c, song_done, c >= 34); else pass_cnt++;
            tick();
        end
        total_cnt++; if (song_note !== 15'd0) $display("FAIL rest_note got %0h exp 0", song_note); else pass_cnt++;
        $display("rest_end: no load, done at 34");
    endtask

    task automatic test_pause;
        start_fresh();
        rom7[0] = w(7, 3, META_NOTE);
        for (int c = 0; c <= 50; c++) begin
            play = !(c >= 10 && c < 30);
            beat = (c == 8 || c == 12 || c == 15 || c == 18 || c == 21 || c == 24 || c == 35 || c == 40);
            if (c == 29) begin
                total_cnt++; if (dut.beat_cnt_reg !== 6'd1) $display("FAIL pause_count got %0d exp 1", dut.beat_cnt_reg); else pass_cnt++;
            end
            if (c == 36) begin
                total_cnt++; if (dut.state_reg !== WAIT_BEATS) $display("FAIL pause_still_waiting got %0d exp WAIT_BEATS", dut.state_reg); else pass_cnt++;
            end
            if (c == 41) begin
                total_cnt++; if (dut.state_reg !== FETCH) $display("FAIL pause_fetch got %0d exp FETCH", dut.state_reg); else pass_cnt++;
            end
            total_cnt++; if (song_done !== (c >= 44)) $display("FAIL pause_done c=%0d got %0b exp %0b", c, song_done, c >= 44); else pass_cnt++;
            tick();
        end
        $display("pause: 5 paused beats ignored, done at 44");
    endtask

    task automatic test_new_song;
        logic [14:0] w2;
        start_fresh();
        w2 = w(9, 0, META_NOTE);
        rom7[0] = w(5, 4, META_NOTE);
        rom7[256] = w2;
        play = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            new_song = (c == 7);
            beat = (c == 7);
            song_select = (c == 7) ? 2'd2 : (c > 7 ? 2'd3 : 2'd0);
            if (c == 8) begin
                total_cnt++; if (dut.state_reg !== IDLE) $display("FAIL newsong_idle got %0d exp IDLE", dut.state_reg); else pass_cnt++;
                total_cnt++; if (rom_addr !== 9'h100) $display("FAIL newsong_addr got %0h exp 100", rom_addr); else pass_cnt++;
            end
            if (c == 9) begin
                total_cnt++; if (dut.state_reg !== FETCH || rom_addr !== 9'h100) $display("FAIL newsong_fetch got state=%0d addr=%0h exp FETCH/100", dut.state_reg, rom_addr); else pass_cnt++;
            end
            total_cnt++; if (load_new_note !== (c == 4 || c == 12)) $display("FAIL newsong_load c=%0d got %0b exp %0b", c, load_new_note, c == 4 || c == 12); else pass_cnt++;
            if (c == 12) begin
                total_cnt++; if (song_note !== w2) $display("FAIL newsong_note got %0h exp %0h", song_note, w2); else pass_cnt++;
            end
            total_cnt++; if (song_done !== (c >= 16)) $display("FAIL newsong_done c=%0d got %0b exp %0b", c, song_done, c >= 16); else pass_cnt++;
            if (c == 20) begin
                total_cnt++; if (rom_addr !== 9'h101) $display("FAIL newsong_end_addr got %0h exp 101", rom_addr); else pass_cnt++;
            end
            tick();
        end
        new_song = 1'b0;
        $display("new_song: restart into song 2, load at 12, done at 16");
    endtask

    task automatic test_reset_load;
        logic [14:0] w0;
        start_fresh();
        w0 = w(40, 2, META_NOTE);
        rom7[0] = w0;
        play = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        total_cnt++; if (load_new_note !== 1'b1) $display("FAIL rstload_pre got %0b exp 1", load_new_note); else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++; if (load_new_note !== 1'b0) $display("FAIL rstload_load got %0b exp 0", load_new_note); else pass_cnt++;
        total_cnt++; if (song_note !== 15'd0 || rom_addr !== 9'd0 || song_done !== 1'b0) $display("FAIL rstload_outs got note=%0h addr=%0h done=%0b exp 0/0/0", song_note, rom_addr, song_done); else pass_cnt++;
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        total_cnt++; if (load_new_note !== 1'b1 || song_note !== w0) $display("FAIL rstload_resume got load=%0b note=%0h exp 1/%0h", load_new_note, song_note, w0); else pass_cnt++;
        $display("reset_load: async abort and restart checked");
    endtask

    task automatic test_wrap;
        int n;
        logic done_at_last;
        start_fresh();
        for (int i = 0; i < 4; i++) rom2[i] = w(i + 1, 1, META_NOTE);
        play = 1'b1;
        n = 0;
        done_at_last = 1'b1;
        for (int c = 0; c < 100; c++) begin
            beat = (c % 5 == 4);
            if (load2) begin
                n++;
                if (n <= 4) begin
                    total_cnt++; if (song_note2 !== rom2[n - 1]) $display("FAIL wrap_note n=%0d got %0h exp %0h", n, song_note2, rom2[n - 1]); else pass_cnt++;
                end
                if (n == 4) done_at_last = done2;
            end
            tick();
        end
        total_cnt++; if (n !== 4) $display("FAIL wrap_loads got %0d exp 4", n); else pass_cnt++;
        total_cnt++; if (done_at_last !== 1'b0) $display("FAIL wrap_early_done got %0b exp 0", done_at_last); else pass_cnt++;
        total_cnt++; if (done2 !== 1'b1) $display("FAIL wrap_done got %0b exp 1", done2); else pass_cnt++;
        $display("wrap: %0d loads from a 4-entry song", n);
    endtask

    task automatic test_random;
        logic [2:0]  metas [0:4];
        logic [14:0] exp_q [$];
        metas[0] = 3'b000; metas[1] = 3'b001; metas[2] = 3'b010; metas[3] = 3'b011; metas[4] = 3'b101;
        for (int it = 0; it < 20; it++) begin
            int sel, n, last_load, cyc, nloads;
            start_fresh();
            exp_q.delete();
            sel = $urandom_range(0, 3);
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                logic [2:0]  m;
                logic [14:0] word;
                m = metas[$urandom_range(0, 4)];
                word = w($urandom_range(0, 63), $urandom_range(0, 3), m);
                rom7[sel * 128 + k] = word;
                if (m != META_REST) exp_q.push_back(word);
            end
            rom7[sel * 128 + n] = w(0, 0, META_END);
            new_song = 1'b1;
            song_select = 2'(sel);
            tick();
            new_song = 1'b0;
            last_load = -100;
            nloads = 0;
            for (cyc = 0; cyc < 2000 && !song_done; cyc++) begin
                play = ($urandom_range(0, 9) != 0);
                beat = ($urandom_range(0, 3) == 0);
                if (load_new_note) begin
                    nloads++;
                    total_cnt++;
                    if (exp_q.size() == 0) $display("FAIL rand_extra_load it=%0d got %0h exp none", it, song_note);
                    else if (song_note !== exp_q[0]) $display("FAIL rand_note it=%0d got %0h exp %0h", it, song_note, exp_q[0]);
                    else pass_cnt++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    total_cnt++; if (cyc - last_load < 3) $display("FAIL rand_spacing it=%0d got %0d exp >=3", it, cyc - last_load); else pass_cnt++;
                    last_load = cyc;
                end
                tick();
            end
            total_cnt++; if (song_done !== 1'b1) $display("FAIL rand_timeout it=%0d got done=%0b exp 1", it, song_done); else pass_cnt++;
            total_cnt++; if (exp_q.size() != 0) $display("FAIL rand_missing it=%0d got %0d pending exp 0", it, exp_q.size()); else pass_cnt++;
            $display("random it=%0d song=%0d entries=%0d loads=%0d cycles=%0d", it, sel, n, nloads, cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_chord();
        test_rest_end();
        test_pause();
        test_new_song();
        test_reset_load();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 Parameter ADDR_W, default 7, per-song note address width (128 entries per song).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 play  input  1  1 = song advances; 0 = paused.
REQ-005 beat  input  1  one-cycle pulse per beat.
REQ-006 new_song  input  1  one-cycle pulse; restart at the entry selected by song_select.
REQ-007 song_select  input  2  song index, sampled only on new_song.
REQ-008 rom_addr  output  2+ADDR_W  {song_sel_q, note_addr} to the song ROM.
REQ-009 rom_data  input  15  ROM word, valid one cycle after rom_addr.
REQ-010 song_note  output  15  note word for the note players, held between loads.
REQ-011 load_new_note  output  1  one-cycle pulse; song_note is valid in that cycle.
REQ-012 song_done  output  1  level; end of song has been reached.

Function
REQ-013 ROM word format: [14:9] note, [8:3] duration in beats, [2:0] meta.
- 000 = note, then wait duration beats.
- 001 = chord member, load with no wait.
- 010 = rest, no load, wait duration beats.
- 111 = end of song.
- Other codes are treated as 000.

REQ-014 FSM states: IDLE, FETCH, WAIT_ROM, DECODE, LOAD, WAIT_BEATS, DONE.

REQ-015 IDLE: go to FETCH when play=1 and song_done=0.

REQ-016 FETCH: drive rom_addr, then go to WAIT_ROM.
- WAIT_ROM: go to DECODE.
- DECODE: capture rom_data.

REQ-017 DECODE transitions:
- meta 111: go to DONE.
- meta 010: go to WAIT_BEATS.
- Otherwise: go to LOAD.

REQ-018 LOAD:
- Put the captured word on song_note and assert load_new_note for exactly that cycle.
- meta 001, or duration 0: go to FETCH.
- Otherwise: go to WAIT_BEATS.

REQ-019 Consecutive load_new_note pulses SHALL be at least 3 cycles apart, so arbiter grants settle between loads.

REQ-020 WAIT_BEATS:
- Count beat pulses only while play=1, starting the cycle after entry.
- When count == duration, go to FETCH.
- A rest with duration 0 goes to FETCH after one cycle.

REQ-021 Pause: with play=0, the beat count is frozen and no FETCH is issued from WAIT_BEATS. A load or fetch already in flight completes.

REQ-022 note_addr increments by 1 on each DECODE that does not end the song.

REQ-023 Address wrap: if DECODE occurs at note_addr = 2^ADDR_W-1 and meta is not 111, treat that entry as the last one. After it completes, go to DONE instead of wrapping.

REQ-024 DONE: song_done=1. Stay in DONE until new_song or reset.

REQ-025 new_song in any state:
- Next state IDLE.
- note_addr=0, beat count=0, song_done=0, song_sel_q=song_select.
- No load_new_note in that cycle.
- new_song has priority over every other transition.

REQ-026 A beat coinciding with the LOAD cycle is not counted.

Reset
REQ-027 On reset low, asynchronously:
- State IDLE.
- note_addr, beat count and song_sel_q = 0.
- song_note = 0, load_new_note = 0, song_done = 0.
- rom_addr = 0.

REQ-028 Reset asserted mid-song aborts the song without emitting a load_new_note pulse. Operation resumes from IDLE after release.

Structure
REQ-029 The shared package song_pkg holds:
- field positions (NOTE_MSB/LSB, DUR_MSB/LSB, META_MSB/LSB);
- meta codes META_NOTE, META_CHORD, META_REST, META_END;
- the FSM state enumeration.

REQ-030 The block is a single module with no sub-modules. The beat counter is 6 bits and internal.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Single note, ROM[0] = {note 12, dur 2, 000}, play=1, beat every 10 cycles:
  - load_new_note at cycle 4 after start, with song_note = ROM[0];
  - FETCH of address 1 after the 2nd beat.
- Chord, ROM[0..2] = 001, 001, 000 (dur 1):
  - three load pulses exactly 4 cycles apart;
  - next fetch after 1 beat.
- Rest and end, ROM[0] = {0, 3, 010}, ROM[1] = {.., 111}:
  - no load pulse;
  - song_done=1 after the 3rd beat plus 3 cycles.
- Pause: play=0 during WAIT_BEATS with 5 beats applied leaves count unchanged. After play=1, the remaining beats are still required.
- new_song with song_select=2 mid-WAIT_BEATS: next cycle IDLE, song_done=0, then rom_addr = {2'b10, 7'd0}.
- Reset low during LOAD: load_new_note=0 immediately and all outputs are zero. With ADDR_W=2 and four 000 entries, song_done is asserted after the 4th note.
